// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit:
// state encoding, opcodes, ALUOP codes, mux encodings and the control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_RTWB    = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEXE = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw Moore control word for one state, before reset gating and zero qualification.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] aluop;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_supported(logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    // Last state of every instruction; an instruction retires while in one of these.
    function automatic logic is_final(state_t s);
        return s inside {S_MEMWB, S_MEMWR, S_RTWB, S_BEQ, S_ADDIWB, S_JUMP};
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bus between the main control unit and the MIPS datapath.
interface mc_control_unit_if;
    import mc_ctrl_pkg::*;

    logic [5:0] opcode;
    logic       zero;
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] ALUOP;
    logic [1:0] pc_source;

    modport master (
        input  opcode, zero,
        output pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, ALUOP, pc_source
    );

    modport slave (
        output opcode, zero,
        input  pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, ALUOP, pc_source
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Pure combinational state -> control word table for the main control FSM.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Moore output table; unlisted fields and unreachable encodings stay 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_RTEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.aluop     = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.aluop         = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS main control FSM: state register, next-state decode,
// retired-instruction counter and reset-gated datapath strobes.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_control_unit_if.master  bus,
    output logic               illegal_op,
    output logic [31:0]        instr_count,
    output logic [3:0]         state_dbg
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    mc_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= state_t'(RESET_STATE);
        else        state <= state_next;
    end

    // Next-state decode; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_next = S_RTEXE;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_ADDI:      state_next = S_ADDIEXE;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTEXE:   state_next = S_RTWB;
            S_ADDIEXE: state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Retired-instruction counter, bumped during each instruction's final state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               instr_count <= '0;
        else if (is_final(state)) instr_count <= instr_count + 32'd1;
    end

    // Datapath outputs; side-effecting strobes are held off while rst_n is low.
    always_comb begin
        bus.pc_en      = rst_n & (ctrl.pc_write | (ctrl.pc_write_cond & bus.zero));
        bus.ir_write   = rst_n & ctrl.ir_write;
        bus.mem_read   = rst_n & ctrl.mem_read;
        bus.mem_write  = rst_n & ctrl.mem_write;
        bus.reg_write  = rst_n & ctrl.reg_write;
        bus.i_or_d     = ctrl.i_or_d;
        bus.mem_to_reg = ctrl.mem_to_reg;
        bus.reg_dst    = ctrl.reg_dst;
        bus.alu_src_a  = ctrl.alu_src_a;
        bus.alu_src_b  = ctrl.alu_src_b;
        bus.ALUOP      = ctrl.aluop;
        bus.pc_source  = ctrl.pc_source;
    end

    // Debug and exception outputs.
    always_comb begin
        illegal_op = (state == S_DECODE) && !op_supported(bus.opcode);
        state_dbg  = state;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle main control FSM for the MIPS datapath. It decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select. It produces the 3-bit ALUOP consumed by the downstream ALU control stage, which expands ALUOP = 3'b010 via the function field.

## Interface
Parameters:
- RESET_STATE, 4'd0: state entered on reset (FETCH); kept configurable for bring-up only.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag, used in the BEQ state.
- pc_en  out  1  PC write enable = pc_write | (pc_write_cond & zero).
- ir_write  out  1  instruction register load.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU operand A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU operand B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- ALUOP  out  3  000 = add, 001 = sub, 010 = use function field.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- instr_count  out  32  count of retired instructions.
- state_dbg  out  4  current state encoding.

## Operation
States and encodings:
- FETCH 0: mem_read, ir_write, alu_src_b = 01, ALUOP = 000, pc_write, pc_source = 00. Next state DECODE.
- DECODE 1: alu_src_b = 11, ALUOP = 000 (branch target into ALUOut). Next state by opcode:
  - 000000 → RTEXE
  - 100011 or 101011 → MEMADR
  - 000100 → BEQ
  - 001000 → ADDIEXE
  - 000010 → JUMP
  - anything else → FETCH, with illegal_op asserted.
- MEMADR 2: alu_src_a = 1, alu_src_b = 10, ALUOP = 000. lw → MEMRD; sw → MEMWR.
- MEMRD 3: mem_read, i_or_d = 1. Next MEMWB.
- MEMWB 4: reg_write, mem_to_reg = 1, reg_dst = 0. Next FETCH.
- MEMWR 5: mem_write, i_or_d = 1. Next FETCH.
- RTEXE 6: alu_src_a = 1, alu_src_b = 00, ALUOP = 010. Next RTWB.
- RTWB 7: reg_write, reg_dst = 1, mem_to_reg = 0. Next FETCH.
- BEQ 8: alu_src_a = 1, alu_src_b = 00, ALUOP = 001, pc_write_cond, pc_source = 01. Next FETCH.
- ADDIEXE 9: alu_src_a = 1, alu_src_b = 10, ALUOP = 000. Next ADDIWB.
- ADDIWB 10: reg_write, reg_dst = 0, mem_to_reg = 0. Next FETCH.
- JUMP 11: pc_write, pc_source = 10. Next FETCH.
- Encodings 12–15 are unreachable; if entered, next state is FETCH and all outputs are inactive.

Output rules:
- Any output not listed for a state is 0 in that state.
- Outputs are Moore (a function of state only), except pc_en, which is combinational on zero.
- opcode is sampled only in DECODE and MEMADR.
- instr_count increments by 1 on the final-state cycle of each instruction: MEMWB, MEMWR, RTWB, BEQ, ADDIWB, JUMP. Illegal opcodes do not count.
- instr_count wraps from 0xFFFFFFFF to 0.

## Timing
- Cycles per instruction: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3, illegal 2.
- Reset:
  - rst_n low immediately forces state = FETCH, instr_count = 0, illegal_op = 0.
  - While rst_n is low, pc_en, ir_write, mem_read, mem_write and reg_write are forced to 0 combinationally. All other outputs take their FETCH values.
  - The first FETCH is performed on the first rising edge after rst_n deasserts.
- Reset mid-instruction abandons the instruction. No write strobe is issued after rst_n falls.
- BEQ: pc_en follows zero within the same cycle. zero = 0 gives a one-cycle state with no PC update.

## Structure
- Shared package mc_ctrl_pkg holds:
  - state enum
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOP constants: ALUOP_ADD = 3'b000, ALUOP_SUB = 3'b001, ALUOP_FUNCT = 3'b010
  - alu_src_b and pc_source encodings
- The ALU control stage imports the same ALUOP constants.
- One sub-module: mc_ctrl_decode, a pure combinational state→outputs table. The FSM register, next-state logic and counter live in mc_control_unit.

## Test plan
- Reset: hold rst_n low for 3 cycles.
  - During reset: all write strobes 0, state_dbg = 0, instr_count = 0.
  - After release, state sequence 0,1,… begins.
- R-type: opcode 000000.
  - State sequence 0,1,6,7,0.
  - ALUOP = 010 in state 6; reg_write = 1 and reg_dst = 1 in state 7.
  - instr_count increments by 1.
- lw then sw: opcodes 100011 then 101011.
  - lw: states 0,1,2,3,4; mem_to_reg = 1 in state 4.
  - sw: states 0,1,2,5; mem_write = 1 only in state 5.
  - instr_count increments by 2.
- beq: opcode 000100.
  - With zero = 1: pc_en = 1 in state 8.
  - With zero = 0: pc_en = 0 in state 8.
  - Both cases return to FETCH, and each retires one instruction.
- Illegal opcode 111111: states 0,1,0; illegal_op pulses for exactly 1 cycle; instr_count unchanged.
- Asynchronous reset asserted in state 3 (MEMRD) of a lw: state_dbg goes to 0 without a clock edge, and reg_write never asserts.
